// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div sequencer and HI/LO owner for the E stage
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_md_op,
    input  logic        i_mt_en,
    input  logic        i_cancel,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nx;
    logic [3:0]  r_count, w_count_nx;
    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic [31:0] w_hi_nx, w_lo_nx, w_pend_hi_nx, w_pend_lo_nx;
    logic        r_done, w_done_nx;

    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_abs_a, w_abs_b, w_dvd, w_dvs, w_q, w_r, w_quot, w_rem;
    logic [31:0] w_res_hi, w_res_lo;
    logic        w_b_zero, w_neg_q, w_neg_r, w_launch, w_mt_hi, w_mt_lo;

    // Both products come from 64-bit multiplies; sign-extending the operands
    // makes the low 64 bits of the unsigned product equal the signed product.
    assign w_prod_u = {32'd0, i_src_a} * {32'd0, i_src_b};
    assign w_prod_s = {{32{i_src_a[31]}}, i_src_a} * {{32{i_src_b[31]}}, i_src_b};

    // One unsigned divider serves div and divu: signed division runs on
    // magnitudes and fixes signs afterwards, so 0x80000000 / -1 yields
    // 0x80000000 with remainder 0 instead of overflowing.
    assign w_abs_a  = i_src_a[31] ? (~i_src_a + 32'd1) : i_src_a;
    assign w_abs_b  = i_src_b[31] ? (~i_src_b + 32'd1) : i_src_b;
    assign w_dvd    = i_md_op[0] ? i_src_a : w_abs_a;
    assign w_dvs    = i_md_op[0] ? i_src_b : w_abs_b;
    assign w_b_zero = (i_src_b == 32'd0);
    assign w_q      = w_b_zero ? 32'd0 : w_dvd / w_dvs;
    assign w_r      = w_b_zero ? 32'd0 : w_dvd % w_dvs;
    assign w_neg_q  = ~i_md_op[0] & (i_src_a[31] ^ i_src_b[31]);
    assign w_neg_r  = ~i_md_op[0] & i_src_a[31];
    assign w_quot   = w_neg_q ? (~w_q + 32'd1) : w_q;
    assign w_rem    = w_neg_r ? (~w_r + 32'd1) : w_r;

    // Divide by zero returns the dividend in HI and all ones in LO.
    assign w_res_hi = i_md_op[1] ? (w_b_zero ? i_src_a : w_rem)
                                 : (i_md_op[0] ? w_prod_u[63:32] : w_prod_s[63:32]);
    assign w_res_lo = i_md_op[1] ? (w_b_zero ? 32'hFFFF_FFFF : w_quot)
                                 : (i_md_op[0] ? w_prod_u[31:0] : w_prod_s[31:0]);

    // A launch needs an idle unit, an arithmetic op and no flush; it also
    // drops any same-cycle mthi/mtlo.
    assign w_launch = (r_state == S_IDLE) & i_start & ~i_md_op[2] & ~i_cancel;
    assign w_mt_hi  = i_mt_en & ~i_cancel & ~w_launch & (i_md_op == 3'b100);
    assign w_mt_lo  = i_mt_en & ~i_cancel & ~w_launch & (i_md_op == 3'b101);

    // Next-state logic: flush beats commit, commit beats a same-cycle mthi/mtlo.
    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = r_count;
        w_pend_hi_nx = r_pend_hi;
        w_pend_lo_nx = r_pend_lo;
        w_hi_nx      = w_mt_hi ? i_src_a : r_hi;
        w_lo_nx      = w_mt_lo ? i_src_a : r_lo;
        w_done_nx    = 1'b0;
        if (i_cancel) begin
            w_state_nx = S_IDLE;
            w_count_nx = 4'd0;
        end else if (r_state == S_RUN) begin
            if (r_count == 4'd1) begin
                w_state_nx = S_IDLE;
                w_count_nx = 4'd0;
                w_hi_nx    = r_pend_hi;
                w_lo_nx    = r_pend_lo;
                w_done_nx  = 1'b1;
            end else begin
                w_count_nx = r_count - 4'd1;
            end
        end else if (w_launch) begin
            w_state_nx   = S_RUN;
            w_count_nx   = i_md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            w_pend_hi_nx = w_res_hi;
            w_pend_lo_nx = w_res_lo;
        end
    end

    // State, countdown, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_pend_hi <= w_pend_hi_nx;
            r_pend_lo <= w_pend_lo_nx;
            r_hi      <= w_hi_nx;
            r_lo      <= w_lo_nx;
            r_done    <= w_done_nx;
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: randomized scoreboard bench for md_sequencer
module tb_md_sequencer;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_mt_en, i_cancel;
    logic [2:0]  i_md_op;
    logic [31:0] i_src_a, i_src_b;
    logic        o_busy, o_done;
    logic [31:0] o_hi, o_lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        prev_done = 1'b0;
    logic [31:0] sp[4] = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_md_op(i_md_op),
        .i_mt_en(i_mt_en), .i_cancel(i_cancel), .i_src_a(i_src_a), .i_src_b(i_src_b),
        .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; return 64'(p); end
            3'd1: begin u = {32'd0, a} * {32'd0, b}; return u; end
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Monitor: every Done pops the oldest expected result.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n) begin
            if (prev_done) chk("done_one_cycle", 64'(o_done), 64'd0);
            if (o_done) begin
                chk("done_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("sb_hilo", {o_hi, o_lo}, e);
                end
            end
            prev_done = o_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input int k_cancel, input int mt_at);
        logic [63:0] e;
        int n, lat;
        e   = model(op, a, b);
        lat = op[1] ? DIV_N : MULT_N;
        @(negedge clk);
        i_start = 1'b1; i_md_op = op; i_src_a = a; i_src_b = b;
        if (k_cancel == 0) sb_q.push_back(e);
        @(negedge clk);
        i_start = hold; i_src_a = $urandom; i_src_b = $urandom;
        n = 0;
        while (o_busy && n < 40) begin
            n++;
            if (n == k_cancel) i_cancel = 1'b1;
            if (n == mt_at) begin i_mt_en = 1'b1; i_md_op = 3'b100; i_src_a = 32'h55; end
            @(negedge clk);
            i_cancel = 1'b0;
            if (i_mt_en) begin
                i_mt_en = 1'b0; i_md_op = op;
                chk("mthi_in_run", {32'd0, o_hi}, 64'h55);
            end
            if (hold) begin i_src_a = $urandom; i_src_b = $urandom; end
        end
        i_start = 1'b0;
        if (k_cancel != 0) begin
            chk("cancel_busy_cycles", 64'(n), 64'(k_cancel));
            chk("cancel_hilo", {o_hi, o_lo}, {m_hi, m_lo});
        end else begin
            chk("busy_cycles", 64'(n), 64'(lat));
            chk("commit_hilo", {o_hi, o_lo}, e);
            m_hi = e[63:32]; m_lo = e[31:0];
        end
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        i_mt_en = 1'b1; i_md_op = op; i_src_a = a; i_src_b = $urandom;
        @(negedge clk);
        i_mt_en = 1'b0;
        if (op == 3'b100) m_hi = a;
        if (op == 3'b101) m_lo = a;
        chk("mt_hilo", {o_hi, o_lo}, {m_hi, m_lo});
        chk("mt_busy", 64'(o_busy), 64'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] op;
        rst_n = 1'b0; i_start = 1'b0; i_mt_en = 1'b0; i_cancel = 1'b0;
        i_md_op = 3'd0; i_src_a = 32'd0; i_src_b = 32'd0;
        #12;
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_hilo", {o_hi, o_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        do_op(3'd3, 32'd7, 32'd0, 0, 0, 0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        do_mt(3'b100, 32'h11);
        do_mt(3'b101, 32'h22);
        do_op(3'd2, 32'd100, 32'd7, 0, 4, 0);
        do_op(3'd2, 32'd100, 32'd7, 0, DIV_N, 0);
        do_op(3'd0, 32'd3, 32'd4, 0, 0, 2);

        @(negedge clk);
        i_start = 1'b1; i_md_op = 3'd0; i_src_a = 32'd5; i_src_b = 32'd7;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_done", 64'(o_done), 64'd0);
        chk("abort_hilo", {o_hi, o_lo}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd0, 32'd9, 32'd9, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0, 1, 2: do_op(op, rnd_opnd(), rnd_opnd(), 0, 0, 0);
                3: do_mt(3'($urandom_range(2, 7)), $urandom);
                4: do_op(op, rnd_opnd(), rnd_opnd(), 0, $urandom_range(1, op[1] ? DIV_N : MULT_N), 0);
                default: begin
                    @(negedge clk);
                    i_start = 1'b1; i_cancel = 1'b1; i_mt_en = 1'b1; i_md_op = op; i_src_a = $urandom;
                    @(negedge clk);
                    i_start = 1'b0; i_cancel = 1'b0; i_mt_en = 1'b0;
                    chk("cancel_start_busy", 64'(o_busy), 64'd0);
                    chk("cancel_start_hilo", {o_hi, o_lo}, {m_hi, m_lo});
                end
            endcase
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO register owner for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu starts and mthi/mtlo writes from the pipeline control unit, and times the operation with a countdown.
- Drives Busy back to the control unit for MD hazard stalls.
- Supports abort on exception/interrupt flush.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, Busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
Start  in  1  launch mult/multu/div/divu this cycle (E-stage Start)
MDOp  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
MTEn  in  1  apply mthi/mtlo write this cycle (MDOp 100/101 only)
Cancel  in  1  flush: suppress same-cycle Start/MTEn, abort running op
SrcA  in  32  rs operand (forwarded)
SrcB  in  32  rt operand (forwarded)
Busy  out  1  operation in flight
Done  out  1  one-cycle pulse, cycle after HI/LO commit
HI  out  32  HI register
LO  out  32  LO register

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, Busy=0, Done=0, state IDLE, count=0, pending results=0.
- States: IDLE (count==0) and RUN (count!=0). Busy = (state==RUN), registered.
- IDLE, Start=1, Cancel=0, MDOp in 000..011, at a rising edge:
  - Load count = MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu; go to RUN.
  - Compute the result from SrcA/SrcB at that edge and hold it in pending HI/LO. Operands are not re-sampled later.
- mult: signed 32x32 to 64 bits; HI=[63:32], LO=[31:0].
- multu: same, unsigned.
- div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (div and divu): HI=SrcA, LO=0xFFFFFFFF; full DIV_CYCLES latency, no flag.
- RUN: count decrements at each edge. At the edge where count==1:
  - HI/LO take the pending values, count goes to 0, state goes to IDLE, Busy falls.
  - Done=1 for exactly the following cycle.
- Latency: Start sampled at edge 0; Busy=1 for exactly N cycles (edges 1..N); HI/LO change at edge N, together with Busy falling.
- Start with MDOp 100..111 is ignored.
- Start while Busy is ignored; the running op continues unchanged. The control unit stalls here, so this is a protocol error, but the block stays safe.
- MTEn=1, Cancel=0, MDOp=100: HI<=SrcA at the edge. MDOp=101: LO<=SrcA. Other MDOp with MTEn: ignored.
- MTEn is honoured in IDLE and in RUN. In RUN the in-flight commit later overwrites the written register.
- MTEn and Start in the same cycle: Start takes priority; MTEn is dropped.
- Cancel=1:
  - Start and MTEn in the same cycle have no effect.
  - If in RUN, go to IDLE at the edge; count=0, Busy=0 next cycle.
  - HI/LO keep their pre-operation values; no Done.
  - If Cancel arrives in the commit cycle (count==1), Cancel wins: no commit.
- Reset asserted mid-operation: immediate abort to reset values; no commit, no Done.
- HI/LO change only at commit, on MTEn, or at reset.
- Outputs are purely registered; no combinational path from inputs to outputs.

Test Plan:
- mult, SrcA=0xFFFFFFFF, SrcB=0x00000002 -> Busy high 5 cycles; at the edge Busy falls HI=0xFFFFFFFF, LO=0xFFFFFFFE; Done high next cycle only.
- multu, same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
- div, SrcA=0xFFFFFFF9 (-7), SrcB=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, SrcA=7, SrcB=0 -> LO=0xFFFFFFFF, HI=0x00000007. Also div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preset HI=0x11, LO=0x22 via mthi/mtlo (each visible the cycle after MTEn). Start div, then Cancel in Busy cycle 4 -> Busy=0 next cycle, HI=0x11, LO=0x22, no Done. Repeat with Cancel in the commit cycle -> same result.
- Start mult, then pulse reset low in Busy cycle 2 -> Busy, Done, HI, LO all 0 immediately. Start held high while Busy -> Busy stays exactly 5 cycles, with no restart.
